// File: rtl/bridge_axi_nx1_sram.sv
// rtl/bridge_axi_nx1_sram.sv - N SRAM-like ports merged onto one AXI3 master; optional RAW guard via BRIDGE_RAW_CHECK_EN
module bridge_axi_nx1_sram #(
    parameter int NUM_PORTS = 2,
    parameter int ID_W      = 4,
    parameter int MAX_RD    = 4,
    parameter int MAX_WR    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    sram_req,
    input  logic [NUM_PORTS-1:0]    sram_wr,
    input  logic [2*NUM_PORTS-1:0]  sram_size,
    input  logic [32*NUM_PORTS-1:0] sram_addr,
    input  logic [4*NUM_PORTS-1:0]  sram_wstrb,
    input  logic [32*NUM_PORTS-1:0] sram_wdata,
    output logic [32*NUM_PORTS-1:0] sram_rdata,
    output logic [NUM_PORTS-1:0]    sram_addr_ok,
    output logic [NUM_PORTS-1:0]    sram_data_ok,
    output logic [ID_W-1:0]         axi_arid,
    output logic [31:0]             axi_araddr,
    output logic [3:0]              axi_arlen,
    output logic [2:0]              axi_arsize,
    output logic [1:0]              axi_arburst,
    output logic [1:0]              axi_arlock,
    output logic [3:0]              axi_arcache,
    output logic [2:0]              axi_arprot,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [ID_W-1:0]         axi_rid,
    input  logic [31:0]             axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    output logic [ID_W-1:0]         axi_awid,
    output logic [31:0]             axi_awaddr,
    output logic [3:0]              axi_awlen,
    output logic [2:0]              axi_awsize,
    output logic [1:0]              axi_awburst,
    output logic [1:0]              axi_awlock,
    output logic [3:0]              axi_awcache,
    output logic [2:0]              axi_awprot,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [ID_W-1:0]         axi_wid,
    output logic [31:0]             axi_wdata,
    output logic [3:0]              axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [ID_W-1:0]         axi_bid,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [3:0] RD_LIMIT = 4'(MAX_RD);
    localparam logic [3:0] WR_LIMIT = 4'(MAX_WR);
    localparam logic [PTR_W:0] PORT_CNT = (PTR_W+1)'(NUM_PORTS);

    logic [PTR_W-1:0]       rr_ptr;
    logic [3:0]             rd_cnt [NUM_PORTS];
    logic [3:0]             wr_cnt [NUM_PORTS];
    logic [3:0]             wr_total;
    logic                   out_of_reset;
    logic                   ar_free;
    logic                   wslot_empty;
    logic [NUM_PORTS-1:0]   elig;
    logic [NUM_PORTS-1:0]   raw_block;
    logic [2*NUM_PORTS-1:0] elig_rot;
    logic [PTR_W-1:0]       win_ofs;
    logic [PTR_W:0]         win_sum;
    logic [PTR_W-1:0]       win;
    logic                   grant_any;
    logic [NUM_PORTS-1:0]   grant;
    logic [NUM_PORTS-1:0]   wr_inc;
    logic [NUM_PORTS-1:0]   rd_inc;
    logic [NUM_PORTS-1:0]   rd_dec;
    logic [NUM_PORTS-1:0]   wr_dec;
    logic [31:0]            sel_addr;
    logic [1:0]             sel_size;
    logic [3:0]             sel_wstrb;
    logic [31:0]            sel_wdata;
    logic                   sel_wr;
    logic                   unused_resp;

    assign unused_resp  = ^{axi_rresp, axi_rlast, axi_bresp};
    assign sram_addr_ok = grant;
    assign axi_rready   = out_of_reset;
    assign axi_bready   = out_of_reset;
    assign axi_arlen    = 4'd0;
    assign axi_arburst  = 2'b01;
    assign axi_arlock   = 2'b00;
    assign axi_arcache  = 4'd0;
    assign axi_arprot   = 3'd0;
    assign axi_awlen    = 4'd0;
    assign axi_awburst  = 2'b01;
    assign axi_awlock   = 2'b00;
    assign axi_awcache  = 4'd0;
    assign axi_awprot   = 3'd0;
    assign axi_wlast    = 1'b1;

    // Per-port eligibility; a port never mixes reads and writes in flight
    always_comb begin
        ar_free     = !axi_arvalid || axi_arready;
        wslot_empty = !axi_awvalid && !axi_wvalid;
        elig        = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sram_req[p] && !sram_wr[p] && ar_free && (rd_cnt[p] < RD_LIMIT)
                && (wr_cnt[p] == 4'd0) && !raw_block[p])
                elig[p] = 1'b1;
            if (sram_req[p] && sram_wr[p] && wslot_empty && (wr_total < WR_LIMIT)
                && (rd_cnt[p] == 4'd0))
                elig[p] = 1'b1;
        end
        if (reset)
            elig = '0;
    end

    // Round-robin pick: first eligible port at or after rr_ptr
    always_comb begin
        elig_rot  = {elig, elig} >> rr_ptr;
        grant_any = 1'b0;
        win_ofs   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                grant_any = 1'b1;
                win_ofs   = PTR_W'(k);
            end
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, win_ofs};
        if (win_sum >= PORT_CNT)
            win_sum = win_sum - PORT_CNT;
        win = win_sum[PTR_W-1:0];
        for (int p = 0; p < NUM_PORTS; p++)
            grant[p] = grant_any && (win == PTR_W'(p));
    end

    // Mux the winning port's request fields and decode response handshakes
    always_comb begin
        sel_addr  = '0;
        sel_size  = '0;
        sel_wstrb = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                sel_addr  = sram_addr[32*p +: 32];
                sel_size  = sram_size[2*p +: 2];
                sel_wstrb = sram_wstrb[4*p +: 4];
                sel_wdata = sram_wdata[32*p +: 32];
                sel_wr    = sram_wr[p];
            end
        end
        rd_inc = grant & ~sram_wr;
        wr_inc = grant & sram_wr;
        // IDs outside the port range match no p, so they are silently dropped
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_dec[p] = axi_rvalid && axi_rready && (axi_rid == ID_W'(p));
            wr_dec[p] = axi_bvalid && axi_bready && (axi_bid == ID_W'(p));
        end
    end

    // Arbiter pointer, ready enables and the AR / AW / W request slots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            out_of_reset <= 1'b0;
            axi_arvalid  <= 1'b0;
            axi_arid     <= '0;
            axi_araddr   <= '0;
            axi_arsize   <= '0;
            axi_awvalid  <= 1'b0;
            axi_wvalid   <= 1'b0;
            axi_awid     <= '0;
            axi_awaddr   <= '0;
            axi_awsize   <= '0;
            axi_wid      <= '0;
            axi_wdata    <= '0;
            axi_wstrb    <= '0;
        end else begin
            out_of_reset <= 1'b1;
            if (grant_any)
                rr_ptr <= (win == PTR_W'(NUM_PORTS - 1)) ? '0 : win + PTR_W'(1);
            if (grant_any && !sel_wr) begin
                axi_arvalid <= 1'b1;
                axi_arid    <= ID_W'(win);
                axi_araddr  <= sel_addr;
                axi_arsize  <= {1'b0, sel_size};
            end else if (axi_arready) begin
                axi_arvalid <= 1'b0;
            end
            if (grant_any && sel_wr) begin
                axi_awvalid <= 1'b1;
                axi_wvalid  <= 1'b1;
                axi_awid    <= ID_W'(win);
                axi_awaddr  <= sel_addr;
                axi_awsize  <= {1'b0, sel_size};
                axi_wid     <= ID_W'(win);
                axi_wdata   <= sel_wdata;
                axi_wstrb   <= sel_wstrb;
            end else begin
                if (axi_awready)
                    axi_awvalid <= 1'b0;
                if (axi_wready)
                    axi_wvalid <= 1'b0;
            end
        end
    end

    // Outstanding counters, read data capture and data_ok pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_cnt[p] <= 4'd0;
                wr_cnt[p] <= 4'd0;
            end
            wr_total     <= 4'd0;
            sram_rdata   <= '0;
            sram_data_ok <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_cnt[p] <= rd_cnt[p] + {3'b0, rd_inc[p]} - {3'b0, rd_dec[p]};
                wr_cnt[p] <= wr_cnt[p] + {3'b0, wr_inc[p]} - {3'b0, wr_dec[p]};
                if (rd_dec[p])
                    sram_rdata[32*p +: 32] <= axi_rdata;
            end
            wr_total     <= wr_total + {3'b0, |wr_inc} - {3'b0, |wr_dec};
            sram_data_ok <= rd_dec | wr_dec;
        end
    end

`ifdef BRIDGE_RAW_CHECK_EN
    localparam int BUF_W = (MAX_WR > 1) ? $clog2(MAX_WR) : 1;

    logic [29:0]      raw_addr [MAX_WR];
    logic [MAX_WR-1:0] raw_vld;
    logic [BUF_W-1:0] raw_head;
    logic [BUF_W-1:0] raw_tail;

    function automatic logic [BUF_W-1:0] bump(input logic [BUF_W-1:0] v);
        return (v == BUF_W'(MAX_WR - 1)) ? '0 : v + BUF_W'(1);
    endfunction

    // A read is held off while any pending write covers the same word
    always_comb begin
        raw_block = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            for (int e = 0; e < MAX_WR; e++)
                if (raw_vld[e] && (raw_addr[e] == sram_addr[32*p+2 +: 30]))
                    raw_block[p] = 1'b1;
    end

    // Write-address FIFO: allocate on write grant, retire oldest on any B
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < MAX_WR; e++)
                raw_addr[e] <= '0;
            raw_vld  <= '0;
            raw_head <= '0;
            raw_tail <= '0;
        end else begin
            if (|wr_inc) begin
                raw_addr[raw_tail] <= sel_addr[31:2];
                raw_vld[raw_tail]  <= 1'b1;
                raw_tail           <= bump(raw_tail);
            end
            if (|wr_dec) begin
                raw_vld[raw_head] <= 1'b0;
                raw_head          <= bump(raw_head);
            end
        end
    end
`else
    // Without the guard, reads are free to pass earlier writes
    always_comb raw_block = '0;
`endif

endmodule
